// File: rtl/l2_lookup_ctrl_pkg.sv
// Shared constants, address views and state encoding for the L2 lookup sequencer.
package l2_lookup_ctrl_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int L2_SET_BITS    = 8;
  localparam int L2_TAG_BITS    = ADDR_BITS - L2_SET_BITS - OFFSET_BITS;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int L2_WAYS        = 4;
  localparam int L2_WAY_BITS    = $clog2(L2_WAYS);

  // Set index position inside a full byte address.
  localparam int SET_LSB = OFFSET_BITS;

  typedef logic [L2_WAY_BITS-1:0] l2_way_t;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0] tag;
    logic [L2_SET_BITS-1:0] set;
    logic [OFFSET_BITS-1:0] off;
  } addr_breakdown_t;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0] tag;
    logic [L2_SET_BITS-1:0] set;
  } line_breakdown_l2_t;

  // Lookup mode encodings driven on lookup_mode.
  localparam logic L2_LOOKUP     = 1'b0;
  localparam logic L2_LOOKUP_FWD = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    LOOKUP  = 2'd2,
    RESP    = 2'd3
  } l2_lookup_ctrl_state_t;

  // Round-robin successor of a way index, wrapping at L2_WAYS-1.
  function automatic l2_way_t next_way(input l2_way_t w);
    if (w == l2_way_t'(L2_WAYS - 1)) return '0;
    return w + 1'b1;
  endfunction

endpackage

// File: rtl/l2_lookup_arb.sv
// Two-way priority arbiter: forwards win, except that a waiting CPU request
// is granted once FWD_STREAK_MAX forwards have been granted ahead of it.
module l2_lookup_arb #(
  parameter int FWD_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpu_valid,
  input  logic fwd_valid,
  output logic cpu_grant,
  output logic fwd_grant
);

  localparam int SW = $clog2(FWD_STREAK_MAX + 1);

  logic [SW-1:0] streak;
  logic          cpu_starved;

  assign cpu_starved = cpu_valid && (streak == SW'(FWD_STREAK_MAX));
  assign fwd_grant   = en && fwd_valid && !cpu_starved;
  assign cpu_grant   = en && cpu_valid && !fwd_grant;

  // Count forward grants that overtake a waiting CPU request; only evaluated while arbitrating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (en) begin
      if (cpu_grant || !cpu_valid) begin
        streak <= '0;
      end else if (fwd_grant && (streak != SW'(FWD_STREAK_MAX))) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_lookup_ctrl.sv
// L2 lookup sequencer: arbitrate, read tags, fire one lookup, return the
// captured result on a valid/ready port, and maintain the eviction pointer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request readys are asserted only in IDLE, at most one at a time,
// and may depend combinationally on valid. rsp_valid stays high with rsp_*
// stable until the cycle rsp_ready is sampled high.
module l2_lookup_ctrl
  import l2_lookup_ctrl_pkg::*;
#(
  parameter int TAG_RD_LAT     = 1,
  parameter int FWD_STREAK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic [ADDR_BITS-1:0]      cpu_req_addr,
  input  logic                      fwd_req_valid,
  output logic                      fwd_req_ready,
  input  logic [LINE_ADDR_BITS-1:0] fwd_req_addr,
  output logic                      tag_rd_en,
  output logic [L2_SET_BITS-1:0]    tag_rd_set,
  output logic                      lookup_en,
  output logic                      lookup_mode,
  output logic [ADDR_BITS-1:0]      lk_addr_buf,
  input  logic                      tag_hit,
  input  logic                      empty_way_found,
  input  l2_way_t                   way_hit,
  input  l2_way_t                   empty_way,
  output l2_way_t                   evict_way_buf,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_src,
  output logic                      rsp_hit,
  output logic                      rsp_empty_found,
  output l2_way_t                   rsp_way,
  output l2_way_t                   rsp_empty_way,
  output l2_lookup_ctrl_state_t     dbg_state
);

  localparam int CW = $clog2(TAG_RD_LAT + 1);

  l2_lookup_ctrl_state_t state, state_next;
  logic [CW-1:0]         rd_cnt;
  logic                  src_buf;
  logic                  arb_en, cpu_grant, fwd_grant, grant;

  // Arbitration is blocked while reset is asserted so no ready leaks out.
  assign arb_en        = (state == IDLE) && rst;
  assign grant         = cpu_grant || fwd_grant;
  assign cpu_req_ready = cpu_grant;
  assign fwd_req_ready = fwd_grant;
  assign rsp_valid     = (state == RESP);
  assign dbg_state     = state;

  l2_lookup_arb #(.FWD_STREAK_MAX(FWD_STREAK_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .cpu_valid (cpu_req_valid),
    .fwd_valid (fwd_req_valid),
    .cpu_grant (cpu_grant),
    .fwd_grant (fwd_grant)
  );

  // Next-state and strobes; tag read set comes straight from the granted address.
  always_comb begin
    state_next  = state;
    tag_rd_en   = 1'b0;
    tag_rd_set  = '0;
    lookup_en   = 1'b0;
    lookup_mode = L2_LOOKUP;
    case (state)
      IDLE: begin
        if (grant) begin
          tag_rd_en  = 1'b1;
          tag_rd_set = fwd_grant ? fwd_req_addr[L2_SET_BITS-1:0]
                                 : cpu_req_addr[SET_LSB +: L2_SET_BITS];
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt == CW'(TAG_RD_LAT - 1)) state_next = LOOKUP;
      end
      LOOKUP: begin
        lookup_en   = 1'b1;
        lookup_mode = src_buf ? L2_LOOKUP_FWD : L2_LOOKUP;
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Tag read latency counter: restarts on grant, advances while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rd_cnt <= '0;
    else if (grant)            rd_cnt <= '0;
    else if (state == RD_WAIT) rd_cnt <= rd_cnt + 1'b1;
  end

  // Latch the granted request; forwards are widened to a line-aligned byte address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_addr_buf <= '0;
      src_buf     <= 1'b0;
    end else if (grant) begin
      lk_addr_buf <= fwd_grant ? {fwd_req_addr, {OFFSET_BITS{1'b0}}} : cpu_req_addr;
      src_buf     <= fwd_grant;
    end
  end

  // Capture lookup results on entry to RESP; forwards never report an empty way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_src         <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_empty_found <= 1'b0;
      rsp_way         <= '0;
      rsp_empty_way   <= '0;
    end else if (state == LOOKUP) begin
      rsp_src         <= src_buf;
      rsp_hit         <= tag_hit;
      rsp_empty_found <= empty_way_found && !src_buf;
      rsp_way         <= way_hit;
      rsp_empty_way   <= empty_way;
    end
  end

  // Advance the eviction pointer when a CPU miss with no free way is handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_way_buf <= '0;
    end else if ((state == RESP) && rsp_ready && !rsp_src && !rsp_hit && !rsp_empty_found) begin
      evict_way_buf <= next_way(evict_way_buf);
    end
  end

endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// Testbench for l2_lookup_ctrl: directed scenarios plus a response scoreboard.
module tb_l2_lookup_ctrl;
  import l2_lookup_ctrl_pkg::*;

  localparam int RW = 3 + 2 * L2_WAY_BITS;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      cpu_req_valid = 1'b0;
  logic                      cpu_req_ready;
  logic [ADDR_BITS-1:0]      cpu_req_addr = '0;
  logic                      fwd_req_valid = 1'b0;
  logic                      fwd_req_ready;
  logic [LINE_ADDR_BITS-1:0] fwd_req_addr = '0;
  logic                      tag_rd_en;
  logic [L2_SET_BITS-1:0]    tag_rd_set;
  logic                      lookup_en;
  logic                      lookup_mode;
  logic [ADDR_BITS-1:0]      lk_addr_buf;
  logic                      tag_hit = 1'b0;
  logic                      empty_way_found = 1'b0;
  l2_way_t                   way_hit = '0;
  l2_way_t                   empty_way = '0;
  l2_way_t                   evict_way_buf;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic                      rsp_src;
  logic                      rsp_hit;
  logic                      rsp_empty_found;
  l2_way_t                   rsp_way;
  l2_way_t                   rsp_empty_way;
  l2_lookup_ctrl_state_t     dbg_state;

  logic [RW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  l2_way_t       exp_evict = '0;

  l2_lookup_ctrl #(.TAG_RD_LAT(1), .FWD_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .fwd_req_valid(fwd_req_valid), .fwd_req_ready(fwd_req_ready), .fwd_req_addr(fwd_req_addr),
    .tag_rd_en(tag_rd_en), .tag_rd_set(tag_rd_set),
    .lookup_en(lookup_en), .lookup_mode(lookup_mode), .lk_addr_buf(lk_addr_buf),
    .tag_hit(tag_hit), .empty_way_found(empty_way_found), .way_hit(way_hit), .empty_way(empty_way),
    .evict_way_buf(evict_way_buf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_hit(rsp_hit),
    .rsp_empty_found(rsp_empty_found), .rsp_way(rsp_way), .rsp_empty_way(rsp_empty_way),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: push expected on grant, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst) begin
      if (cpu_req_ready || fwd_req_ready) begin
        checks++;
        if (cpu_req_ready && fwd_req_ready) begin
          errors++;
          $display("FAIL two_readys: cpu_ready=%b fwd_ready=%b, required at most one", cpu_req_ready, fwd_req_ready);
        end
        if (cpu_req_ready) exp_q.push_back({L2_LOOKUP, tag_hit, empty_way_found, way_hit, empty_way});
        else               exp_q.push_back({L2_LOOKUP_FWD, tag_hit, 1'b0, way_hit, empty_way});
      end
      if (rsp_valid && rsp_ready) begin
        logic [RW-1:0] got, exp;
        got = {rsp_src, rsp_hit, rsp_empty_found, rsp_way, rsp_empty_way};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %b with no outstanding request", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rsp_fields: got {src,hit,ef,way,ew}=%b required %b", got, exp);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic set_dp(input logic hit, input logic ef, input l2_way_t w, input l2_way_t ew);
    tag_hit = hit; empty_way_found = ef; way_hit = w; empty_way = ew;
  endtask

  task automatic send_cpu(input logic [ADDR_BITS-1:0] addr);
    bit ok = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_addr = addr;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cpu_req_ready) ok = 1;
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL cpu_grant_timeout: ready=0 after 100 cycles, required 1");
    end
  endtask

  task automatic send_fwd(input logic [LINE_ADDR_BITS-1:0] laddr);
    bit ok = 0;
    @(posedge clk); #1;
    fwd_req_valid = 1'b1; fwd_req_addr = laddr;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (fwd_req_ready) ok = 1;
    end
    @(posedge clk); #1;
    fwd_req_valid = 1'b0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL fwd_grant_timeout: ready=0 after 100 cycles, required 1");
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == IDLE && exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL idle_timeout: state=%0d pending=%0d, required IDLE with none pending", dbg_state, exp_q.size());
    end
  endtask

  task automatic check_evict(input string name);
    checks++;
    if (evict_way_buf !== exp_evict) begin
      errors++;
      $display("FAIL %s: evict_way_buf=%0d required %0d", name, evict_way_buf, exp_evict);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [127:0] outs;
    outs = {cpu_req_ready, fwd_req_ready, tag_rd_en, tag_rd_set, lookup_en, lookup_mode,
            lk_addr_buf, evict_way_buf, rsp_valid, rsp_src, rsp_hit, rsp_empty_found,
            rsp_way, rsp_empty_way, dbg_state};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required all zero", name, outs);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    cpu_req_valid = 1'b1;
    fwd_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    cpu_req_valid = 1'b0;
    fwd_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_cpu_latency();
    logic [ADDR_BITS-1:0] addr;
    addr = {18'h1234, 8'd5, 6'd0};
    set_dp(1'b0, 1'b1, 2'd0, 2'd3);
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_addr = addr;
    @(negedge clk);
    checks++;
    if ({cpu_req_ready, tag_rd_en, tag_rd_set} !== {1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL lat_grant: ready=%b rd_en=%b set=%0d required 1 1 5", cpu_req_ready, tag_rd_en, tag_rd_set);
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({lookup_en, rsp_valid, tag_rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL lat_t1: lookup_en=%b rsp_valid=%b rd_en=%b required 0 0 0", lookup_en, rsp_valid, tag_rd_en);
    end
    @(negedge clk);
    checks++;
    if ({lookup_en, lookup_mode, rsp_valid, lk_addr_buf} !== {1'b1, L2_LOOKUP, 1'b0, addr}) begin
      errors++;
      $display("FAIL lat_t2: lookup_en=%b mode=%b rsp_valid=%b addr=%h required 1 0 0 %h",
               lookup_en, lookup_mode, rsp_valid, lk_addr_buf, addr);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, lookup_en} !== 2'b10) begin
      errors++;
      $display("FAIL lat_t3: rsp_valid=%b lookup_en=%b required 1 0", rsp_valid, lookup_en);
    end
    wait_idle();
    check_evict("lat_evict_unchanged");
  endtask

  task automatic test_back_to_back();
    logic [9:0] got_vec = '0;
    logic [9:0] exp_vec;
    int n = 0;
    exp_vec = 10'b0111101111; // bit 0 first grant, 1 = FWD
    set_dp(1'b1, 1'b0, 2'd1, 2'd2);
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_addr = {18'h00abc, 8'd17, 6'd4};
    fwd_req_valid = 1'b1; fwd_req_addr = {18'h00def, 8'd33};
    for (int cyc = 0; cyc < 400 && n < 10; cyc++) begin
      @(negedge clk);
      if (cpu_req_ready || fwd_req_ready) begin
        got_vec[n] = fwd_req_ready;
        n++;
        if (n == 10) begin
          @(posedge clk); #1;
          cpu_req_valid = 1'b0;
          fwd_req_valid = 1'b0;
        end
      end
    end
    checks++;
    if (n != 10 || got_vec !== exp_vec) begin
      errors++;
      $display("FAIL b2b_order: grants=%0d order=%b required 10 grants order=%b", n, got_vec, exp_vec);
    end
    cpu_req_valid = 1'b0;
    fwd_req_valid = 1'b0;
    wait_idle();
    check_evict("b2b_evict_unchanged");
  endtask

  task automatic test_hold_rsp();
    logic [RW-1:0] snap;
    bit ok = 0;
    set_dp(1'b1, 1'b0, 2'd2, 2'd1);
    rsp_ready = 1'b0;
    send_cpu({18'h2aaaa, 8'd200, 6'd8});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_rsp_valid: rsp_valid=0 after 20 cycles, required 1");
    end
    snap = {rsp_src, rsp_hit, rsp_empty_found, rsp_way, rsp_empty_way};
    @(posedge clk); #1;
    fwd_req_valid = 1'b1; fwd_req_addr = {18'h01111, 8'd9};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_src, rsp_hit, rsp_empty_found, rsp_way, rsp_empty_way} !== {1'b1, snap} ||
          lookup_en !== 1'b0 || cpu_req_ready !== 1'b0 || fwd_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b rsp=%b lookup_en=%b readys=%b%b required 1 %b 0 00",
                 i, rsp_valid, {rsp_src, rsp_hit, rsp_empty_found, rsp_way, rsp_empty_way},
                 lookup_en, cpu_req_ready, fwd_req_ready, snap);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (fwd_req_ready) ok = 1;
    end
    @(posedge clk); #1;
    fwd_req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_then_fwd: fwd_ready=0 after release, required 1");
    end
    wait_idle();
    check_evict("hold_evict_unchanged");
  endtask

  task automatic test_evict();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      set_dp(1'b0, 1'b0, l2_way_t'($urandom_range(0, 3)), l2_way_t'($urandom_range(0, 3)));
      send_cpu({18'($urandom_range(0, 262143)), 8'($urandom_range(0, 255)), 6'd0});
      wait_idle();
      exp_evict = l2_way_t'(exp_seq[i]);
      check_evict("evict_miss");
    end
    set_dp(1'b1, 1'b0, 2'd3, 2'd0);
    send_cpu({18'h00001, 8'd1, 6'd0});
    wait_idle();
    check_evict("evict_hit_unchanged");
    set_dp(1'b0, 1'b1, 2'd0, 2'd2);
    send_cpu({18'h00002, 8'd2, 6'd0});
    wait_idle();
    check_evict("evict_empty_unchanged");
    set_dp(1'b0, 1'b0, 2'd0, 2'd0);
    send_fwd({18'h00003, 8'd3});
    wait_idle();
    check_evict("evict_fwd_unchanged");
  endtask

  task automatic test_fwd_empty();
    bit ok = 0;
    set_dp(1'b0, 1'b1, 2'd3, 2'd2);
    send_fwd({18'h3ffff, 8'd77});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    checks++;
    if (!ok || rsp_empty_found !== 1'b0 || rsp_src !== 1'b1 || lk_addr_buf !== {18'h3ffff, 8'd77, 6'd0}) begin
      errors++;
      $display("FAIL fwd_empty: valid=%b empty_found=%b src=%b addr=%h required 1 0 1 %h",
               rsp_valid, rsp_empty_found, rsp_src, lk_addr_buf, {18'h3ffff, 8'd77, 6'd0});
    end
    wait_idle();
    check_evict("fwd_empty_evict_unchanged");
  endtask

  task automatic test_reset_mid();
    set_dp(1'b0, 1'b0, 2'd1, 2'd1);
    send_cpu({18'h0beef, 8'd44, 6'd0});
    cpu_req_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    exp_q.delete();
    exp_evict = '0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_idle: state=%0d required %0d", dbg_state, IDLE);
    end
    send_cpu({18'h0cafe, 8'd45, 6'd0});
    wait_idle();
    exp_evict = 2'd1;
    check_evict("reset_mid_after");
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_cpu_latency();
    test_back_to_back();
    test_hold_rsp();
    test_evict();
    test_fwd_empty();
    test_reset_mid();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
